// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Instruction-memory read port, redirect input and decode
//               handshake bundle for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if;
    logic [19:0] fetch_addr;
    logic        fetch_rd_en;
    logic [15:0] fetch_data;
    logic        redirect_valid;
    logic [19:0] redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn_out;
    logic        insn_long;
    logic [19:0] insn_pc;

    // master: the fetch unit itself
    modport master (
        output fetch_addr, fetch_rd_en, insn_valid, insn_out, insn_long, insn_pc,
        input  fetch_data, redirect_valid, redirect_pc, insn_ready
    );

    // slave: memory, branch unit and decode seen from the fetch unit
    modport slave (
        input  fetch_addr, fetch_rd_en, insn_valid, insn_out, insn_long, insn_pc,
        output fetch_data, redirect_valid, redirect_pc, insn_ready
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch PC, 16-bit word queue and 16/32-bit instruction
//               assembly. Define FETCH_LONG_INSN_EN to enable 32-bit insns.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [19:0] RESET_PC = 20'h00000,
    parameter int          QDEPTH   = 4
) (
    input  wire logic                clock,
    input  wire logic                reset,
    instruction_fetch_unit_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [19:0]   r_fetch_pc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [15:0]   r_word [QDEPTH];
    logic [19:0]   r_addr [QDEPTH];

    logic          w_valid;
    logic          w_long;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_pop_n;
    logic [PW-1:0] w_tail;
    logic [15:0]   w_head_word;
    logic [15:0]   w_insn_hi;

    // Head classification only looks at registered state, so insn_valid
    // never depends combinationally on insn_ready.
    always_comb begin
        w_head_word = r_word[r_head];
        w_long      = 1'b0;
        w_insn_hi   = 16'h0000;
`ifdef FETCH_LONG_INSN_EN
        w_long      = w_head_word[15];
        w_insn_hi   = w_long ? r_word[r_head + PW'(1)] : 16'h0000;
        w_valid     = w_long ? (r_count >= CW'(2)) : (r_count >= CW'(1));
`else
        w_valid     = (r_count >= CW'(1));
`endif
    end

    always_comb begin
        w_pop   = w_valid && bus.insn_ready;
        w_pop_n = w_pop ? (w_long ? CW'(2) : CW'(1)) : CW'(0);
        // A pop in the same cycle always frees at least one slot.
        w_push  = !bus.redirect_valid && ((r_count < CW'(QDEPTH)) || w_pop);
        w_tail  = r_head + r_count[PW-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_head     <= '0;
            r_fetch_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_count    <= '0;
            r_fetch_pc <= bus.redirect_pc;
        end else begin
            r_head  <= r_head + w_pop_n[PW-1:0];
            r_count <= r_count + CW'(w_push) - w_pop_n;
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 20'd1;
            end
        end
    end

    // Queue storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_word[w_tail] <= bus.fetch_data;
            r_addr[w_tail] <= r_fetch_pc;
        end
    end

    assign bus.fetch_addr  = r_fetch_pc;
    assign bus.fetch_rd_en = w_push;
    assign bus.insn_valid  = w_valid;
    assign bus.insn_long   = w_valid && w_long;
    assign bus.insn_out    = w_valid ? {w_insn_hi, w_head_word} : 32'h0000_0000;
    assign bus.insn_pc     = w_valid ? r_addr[r_head] : 20'h00000;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed plus randomized bench with an instruction-stream
//               reference model for instruction_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    logic [15:0] mem [1024];

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(20'h00000), .QDEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always_comb bus.fetch_data = mem[bus.fetch_addr[9:0]];

    function automatic logic [15:0] rd(input logic [19:0] a);
        return mem[a[9:0]];
    endfunction

    function automatic bit is_long(input logic [15:0] w);
`ifdef FETCH_LONG_INSN_EN
        return w[15];
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: the next instruction decode must see is the one at
    // exp_pc; its contents follow directly from memory and the length rule.
    logic [19:0] exp_pc = 20'h00000;
    bit          hold_pend = 1'b0;
    logic [31:0] hold_out;
    logic [19:0] hold_pc;
    logic        hold_long;
    int          streak = 0;

    always @(negedge clock) begin
        if (mon_en) begin
            if (reset) begin
                exp_pc    = 20'h00000;
                hold_pend = 1'b0;
                streak    = 0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", bus.insn_valid, 1'b1);
                    chk("hold_out", bus.insn_out, hold_out);
                    chk("hold_pc", bus.insn_pc, hold_pc);
                    chk("hold_long", bus.insn_long, hold_long);
                end
                if (!bus.insn_valid) begin
                    chk("idle_zero", {bus.insn_out, bus.insn_pc, bus.insn_long}, '0);
                    if (!bus.redirect_valid) begin
                        streak++;
                        chk("liveness", streak <= 2, 1'b1);
                    end else begin
                        streak = 0;
                    end
                end else begin
                    streak = 0;
                end
                if (bus.redirect_valid) chk("redir_rd_en", bus.fetch_rd_en, 1'b0);
                if (bus.insn_valid && bus.insn_ready) begin
                    chk("hs_pc", bus.insn_pc, exp_pc);
                    chk("hs_long", bus.insn_long, is_long(rd(exp_pc)));
                    chk("hs_out", bus.insn_out, is_long(rd(exp_pc)) ?
                        {rd(exp_pc + 20'd1), rd(exp_pc)} : {16'h0000, rd(exp_pc)});
                    exp_pc = exp_pc + (is_long(rd(exp_pc)) ? 20'd2 : 20'd1);
                end
                if (bus.redirect_valid) exp_pc = bus.redirect_pc;
                hold_pend = bus.insn_valid && !bus.insn_ready && !bus.redirect_valid;
                hold_out  = bus.insn_out;
                hold_pc   = bus.insn_pc;
                hold_long = bus.insn_long;
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
        mem[0]     = 16'h1234;
        mem[10'h100] = 16'h0777;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 20'h00000;
        bus.insn_ready     = 1'b1;

        // Reset state and first short instruction
        tick(); tick();
        mon_en = 1'b1;
        reset  = 1'b0;
        #1;
        chk("rst_valid", bus.insn_valid, 1'b0);
        chk("rst_out", bus.insn_out, 32'h0);
        chk("rst_long", bus.insn_long, 1'b0);
        chk("rst_pc", bus.insn_pc, 20'h0);
        chk("rst_fetch_addr", bus.fetch_addr, 20'h0);
        chk("rst_rd_en", bus.fetch_rd_en, 1'b1);
        tick();
        chk("t1_valid", bus.insn_valid, 1'b1);
        chk("t1_out", bus.insn_out, 32'h0000_1234);
        chk("t1_pc", bus.insn_pc, 20'h0);
        chk("t1_long", bus.insn_long, 1'b0);
        tick(); tick();

        // Backpressure: queue fills, nothing lost on release
        reset = 1'b1; bus.insn_ready = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("full_rd_en", bus.fetch_rd_en, 1'b0);
        chk("full_fetch_addr", bus.fetch_addr, 20'h4);
        bus.insn_ready = 1'b1;
        #1;
        chk("full_pop_rd_en", bus.fetch_rd_en, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("drain_pc", bus.insn_pc, 20'(i));
            tick();
        end

        // Redirect coincident with handshake of pc 2
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 20'h00100;
        #1;
        chk("rhs_pc", bus.insn_pc, 20'h2);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("rhs_empty", bus.insn_valid, 1'b0);
        tick();
        chk("rhs_new_valid", bus.insn_valid, 1'b1);
        chk("rhs_new_pc", bus.insn_pc, 20'h00100);
        tick();

        // 32-bit instruction after redirect
        reset = 1'b1;
        tick();
        mem[4] = 16'h8001; mem[5] = 16'h0002; mem[6] = 16'h0033;
        reset = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 20'h00004;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("lg_lat0", bus.insn_valid, 1'b0);
        tick();
`ifdef FETCH_LONG_INSN_EN
        chk("lg_lat1", bus.insn_valid, 1'b0);
        tick();
        chk("lg_valid", bus.insn_valid, 1'b1);
        chk("lg_out", bus.insn_out, 32'h0002_8001);
        chk("lg_long", bus.insn_long, 1'b1);
        chk("lg_pc", bus.insn_pc, 20'h4);
        tick();
        chk("lg_next_pc", bus.insn_pc, 20'h6);
`else
        chk("sh_valid", bus.insn_valid, 1'b1);
        chk("sh_out", bus.insn_out, 32'h0000_8001);
        chk("sh_long", bus.insn_long, 1'b0);
        chk("sh_pc", bus.insn_pc, 20'h4);
        tick();
        chk("sh_next_pc", bus.insn_pc, 20'h5);
`endif

        // Address wrap at the top of the PC space
        reset = 1'b1;
        tick();
        mem[10'h3FF] = 16'h8ABC; mem[0] = 16'h0055;
        reset = 1'b0; bus.insn_ready = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 20'hFFFFF;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 5 && !bus.insn_valid; i++) tick();
        chk("wrap_valid", bus.insn_valid, 1'b1);
        chk("wrap_pc", bus.insn_pc, 20'hFFFFF);
`ifdef FETCH_LONG_INSN_EN
        chk("wrap_out", bus.insn_out, 32'h0055_8ABC);
`else
        chk("wrap_out", bus.insn_out, 32'h0000_8ABC);
`endif
        bus.insn_ready = 1'b1;
        tick();
`ifdef FETCH_LONG_INSN_EN
        chk("wrap_next_pc", bus.insn_pc, 20'h1);
`else
        chk("wrap_next_pc", bus.insn_pc, 20'h0);
`endif

        // Randomized traffic against the reference model
        reset = 1'b1;
        tick();
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bus.insn_ready     = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = ($urandom_range(0, 3) == 0) ?
                                 (20'hFFFFC + 20'($urandom_range(0, 3))) : 20'($urandom);
            reset              = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; bus.redirect_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
